// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bubble encoding, two-word flag position
// and the fetch/decode buffer state encoding.
package cpu_pkg;

    localparam int          IMM_FLAG_BIT_DEF = 15;
    localparam logic [15:0] NOP_WORD_DEF     = 16'h0000;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_WAIT_IMM = 1'b1
    } fdb_state_e;

endpackage

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode pipeline register. Joins an opcode word that carries the
// immediate flag with the following fetched word into one decode packet,
// emitting bubbles while the immediate is outstanding.
module fetch_decode_buffer
    import cpu_pkg::*;
#(
    parameter int          IMM_FLAG_BIT = IMM_FLAG_BIT_DEF,
    parameter logic [15:0] NOP_WORD     = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_imm,
    output logic        out_has_imm,
    output logic [31:0] out_pc,
    output logic        imm_pending
);

    fdb_state_e  state_q, state_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_instr_q, out_instr_d;
    logic [15:0] out_imm_q, out_imm_d;
    logic        out_has_imm_q, out_has_imm_d;
    logic [31:0] out_pc_q, out_pc_d;

    // Next-state and next-packet selection: flush clears, stall holds,
    // otherwise assemble single-word or opcode+immediate packets.
    always_comb begin
        state_d       = state_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_imm_d     = out_imm_q;
        out_has_imm_d = out_has_imm_q;
        out_pc_d      = out_pc_q;

        if (flush) begin
            // Pending opcode and any word presented this cycle are dropped.
            state_d       = ST_RUN;
            hold_instr_d  = 16'h0000;
            hold_pc_d     = 32'h0000_0000;
            out_valid_d   = 1'b0;
            out_instr_d   = NOP_WORD;
            out_imm_d     = 16'h0000;
            out_has_imm_d = 1'b0;
            out_pc_d      = 32'h0000_0000;
        end else if (!stall) begin
            // Default to a bubble; out_pc keeps the last packet's address.
            out_valid_d   = 1'b0;
            out_instr_d   = NOP_WORD;
            out_imm_d     = 16'h0000;
            out_has_imm_d = 1'b0;

            unique case (state_q)
                ST_RUN: begin
                    if (in_valid && in_instr[IMM_FLAG_BIT]) begin
                        hold_instr_d = in_instr;
                        hold_pc_d    = in_pc;
                        state_d      = ST_WAIT_IMM;
                    end else if (in_valid) begin
                        out_valid_d = 1'b1;
                        out_instr_d = in_instr;
                        out_pc_d    = in_pc;
                    end
                end
                ST_WAIT_IMM: begin
                    // The word arriving here is data only, whatever its flag bit says.
                    if (in_valid) begin
                        out_valid_d   = 1'b1;
                        out_instr_d   = hold_instr_q;
                        out_imm_d     = in_instr;
                        out_has_imm_d = 1'b1;
                        out_pc_d      = hold_pc_q;
                        state_d       = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State, holding and packet registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            hold_instr_q  <= 16'h0000;
            hold_pc_q     <= 32'h0000_0000;
            out_valid_q   <= 1'b0;
            out_instr_q   <= NOP_WORD;
            out_imm_q     <= 16'h0000;
            out_has_imm_q <= 1'b0;
            out_pc_q      <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_imm_q     <= out_imm_d;
            out_has_imm_q <= out_has_imm_d;
            out_pc_q      <= out_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_imm     = out_imm_q;
    assign out_has_imm = out_has_imm_q;
    assign out_pc      = out_pc_q;
    assign imm_pending = (state_q == ST_WAIT_IMM);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: behavioural packet model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_fetch_decode_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic [31:0] in_pc = 32'h0;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic        out_has_imm;
    logic [31:0] out_pc;
    logic        imm_pending;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_decode_buffer dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_imm(out_imm),
        .out_has_imm(out_has_imm), .out_pc(out_pc), .imm_pending(imm_pending)
    );

    always #5 clk = ~clk;

    // Behavioural model: a pending opcode slot and the expected packet.
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_imm = 16'h0000;
    logic        m_has = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic        m_have_op = 1'b0;
    logic [15:0] m_op = 16'h0000;
    logic [31:0] m_op_pc = 32'h0;
    logic        model_ready = 1'b0;

    always @(posedge clk) begin
        model_ready = 1'b1;
        if (rst || flush) begin
            m_valid = 1'b0; m_instr = 16'h0000; m_imm = 16'h0000; m_has = 1'b0;
            m_pc = 32'h0; m_have_op = 1'b0; m_op = 16'h0000; m_op_pc = 32'h0;
        end else if (!stall) begin
            m_valid = 1'b0; m_instr = 16'h0000; m_imm = 16'h0000; m_has = 1'b0;
            if (in_valid) begin
                if (m_have_op) begin
                    m_valid = 1'b1; m_instr = m_op; m_imm = in_instr;
                    m_has = 1'b1; m_pc = m_op_pc; m_have_op = 1'b0;
                end else if (in_instr[15]) begin
                    m_have_op = 1'b1; m_op = in_instr; m_op_pc = in_pc;
                end else begin
                    m_valid = 1'b1; m_instr = in_instr; m_pc = in_pc;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (model_ready) begin
            chk("m.out_valid",   {31'b0, out_valid},   {31'b0, m_valid});
            chk("m.out_instr",   {16'b0, out_instr},   {16'b0, m_instr});
            chk("m.out_imm",     {16'b0, out_imm},     {16'b0, m_imm});
            chk("m.out_has_imm", {31'b0, out_has_imm}, {31'b0, m_has});
            chk("m.out_pc",      out_pc,               m_pc);
            chk("m.imm_pending", {31'b0, imm_pending}, {31'b0, m_have_op});
        end
    end

    // Present one cycle of inputs; returns just after the consuming edge.
    task automatic drive(input logic r, input logic f, input logic s, input logic v,
                         input logic [15:0] w, input logic [31:0] pc);
        rst = r; flush = f; stall = s; in_valid = v; in_instr = w; in_pc = pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a word presented
        drive(1, 0, 0, 1, 16'h1234, 32'h5);
        drive(1, 0, 0, 1, 16'h1234, 32'h5);
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.instr", {16'b0, out_instr}, 32'h0000);
        chk("rst.pc", out_pc, 32'h0);
        chk("rst.pending", {31'b0, imm_pending}, 32'd0);

        // Single word
        drive(0, 0, 0, 1, 16'h0A05, 32'h20);
        chk("single.valid", {31'b0, out_valid}, 32'd1);
        chk("single.instr", {16'b0, out_instr}, 32'h0A05);
        chk("single.has", {31'b0, out_has_imm}, 32'd0);
        chk("single.pc", out_pc, 32'h20);

        // Two-word instruction
        drive(0, 0, 0, 1, 16'h8A01, 32'h30);
        chk("two.c1.valid", {31'b0, out_valid}, 32'd0);
        chk("two.c1.pending", {31'b0, imm_pending}, 32'd1);
        drive(0, 0, 0, 1, 16'hBEEF, 32'h31);
        chk("two.c2.instr", {16'b0, out_instr}, 32'h8A01);
        chk("two.c2.imm", {16'b0, out_imm}, 32'hBEEF);
        chk("two.c2.has", {31'b0, out_has_imm}, 32'd1);
        chk("two.c2.pc", out_pc, 32'h30);

        // Bubble keeps out_pc
        drive(0, 0, 0, 0, 16'h0000, 32'h0);
        chk("bubble.valid", {31'b0, out_valid}, 32'd0);
        chk("bubble.pc", out_pc, 32'h30);

        // Stall in WAIT_IMM
        drive(0, 0, 0, 1, 16'h8A01, 32'h40);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 16'h1111, 32'h41);
            chk("stall.pending", {31'b0, imm_pending}, 32'd1);
            chk("stall.valid", {31'b0, out_valid}, 32'd0);
        end
        drive(0, 0, 0, 1, 16'h00FF, 32'h41);
        chk("stall.imm", {16'b0, out_imm}, 32'h00FF);
        chk("stall.instr", {16'b0, out_instr}, 32'h8A01);
        chk("stall.pc", out_pc, 32'h40);

        // Flush in WAIT_IMM
        drive(0, 0, 0, 1, 16'h8A01, 32'h50);
        drive(0, 1, 0, 1, 16'hBEEF, 32'h51);
        chk("flush.valid", {31'b0, out_valid}, 32'd0);
        chk("flush.pending", {31'b0, imm_pending}, 32'd0);
        chk("flush.pc", out_pc, 32'h0);
        drive(0, 0, 0, 1, 16'h0A05, 32'h52);
        chk("flush.next.instr", {16'b0, out_instr}, 32'h0A05);
        chk("flush.next.has", {31'b0, out_has_imm}, 32'd0);
        chk("flush.next.pc", out_pc, 32'h52);

        // Flush and stall together while holding a valid packet
        drive(0, 1, 1, 1, 16'h1234, 32'h53);
        chk("flushstall.valid", {31'b0, out_valid}, 32'd0);

        // Immediate word with flag bit set is not decoded
        drive(0, 0, 0, 1, 16'h8002, 32'h60);
        drive(0, 0, 0, 1, 16'h8003, 32'h61);
        chk("immflag.instr", {16'b0, out_instr}, 32'h8002);
        chk("immflag.imm", {16'b0, out_imm}, 32'h8003);
        drive(0, 0, 0, 0, 16'h0000, 32'h0);
        chk("immflag.pending", {31'b0, imm_pending}, 32'd0);

        // WAIT_IMM with gaps in fetch
        drive(0, 0, 0, 1, 16'h8004, 32'h70);
        drive(0, 0, 0, 0, 16'h0000, 32'h0);
        chk("gap.pending", {31'b0, imm_pending}, 32'd1);
        drive(0, 0, 0, 1, 16'h1234, 32'h71);
        chk("gap.instr", {16'b0, out_instr}, 32'h8004);
        chk("gap.imm", {16'b0, out_imm}, 32'h1234);

        // PC at top of address space
        drive(0, 0, 0, 1, 16'h8005, 32'hFFFF_FFFE);
        drive(0, 0, 0, 1, 16'hABCD, 32'hFFFF_FFFF);
        chk("pcwrap.pc", out_pc, 32'hFFFF_FFFE);
        chk("pcwrap.imm", {16'b0, out_imm}, 32'hABCD);

        // Reset mid WAIT_IMM: next word is a fresh opcode
        drive(0, 0, 0, 1, 16'h8006, 32'h80);
        drive(1, 0, 0, 1, 16'h0001, 32'h81);
        drive(0, 0, 0, 1, 16'h8007, 32'h82);
        chk("rstmid.valid", {31'b0, out_valid}, 32'd0);
        chk("rstmid.pending", {31'b0, imm_pending}, 32'd1);
        drive(0, 0, 0, 1, 16'h0001, 32'h83);
        chk("rstmid.instr", {16'b0, out_instr}, 32'h8007);
        chk("rstmid.pc", out_pc, 32'h82);

        // Stall holds a valid packet
        drive(0, 0, 0, 1, 16'h0A05, 32'h90);
        drive(0, 0, 1, 1, 16'h0B06, 32'h91);
        chk("stallhold.valid", {31'b0, out_valid}, 32'd1);
        chk("stallhold.instr", {16'b0, out_instr}, 32'h0A05);
        chk("stallhold.pc", out_pc, 32'h90);

        drive(0, 0, 0, 0, 16'h0000, 32'h0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
